mem_access_unit: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs: control, address, store data.
- Turns each load/store into a single-word request/ready transaction on the data bus.
- Stalls the pipeline while the access is outstanding, then hands load data and fault status to the MEM/WB register.
- Power-aware: bus-facing and result registers load only when needed and hold their value otherwise.

---
 rtl/rv_lsu_pkg.sv | 34 +++
 rtl/lsu_timeout_ctr.sv | 41 ++++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Holds the FSM encoding, fault cause codes and the access legality check.
package rv_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_RW       = 2'b10;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

   localparam int CTRL_READ  = 1;
   localparam int CTRL_WRITE = 0;

   // Read+write together outranks misalignment.
   function automatic logic [1:0] legality_cause(input logic [1:0] ctrl,
                                                 input logic [1:0] addr_lo);
      logic [1:0] cause;
      cause = FAULT_NONE;
      if (ctrl[CTRL_READ] && ctrl[CTRL_WRITE]) begin
         cause = FAULT_RW;
      end else if (addr_lo != 2'b00) begin
         cause = FAULT_MISALIGN;
      end else begin
         cause = FAULT_NONE;
      end
      return cause;
   endfunction

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Wait-cycle counter for the LSU bus timeout.
// tc is high while the count sits at LIMIT-1; LIMIT=0 never raises tc.
module lsu_timeout_ctr #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int CNT_W = (LIMIT <= 1) ? 1 : $clog2(LIMIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'((LIMIT > 0) ? (LIMIT - 1) : 0);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear has priority over increment.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = {CNT_W{1'b0}};
      end else if (en) begin
         count_d = count_q + CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (LIMIT != 0) && (count_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one bus transaction per access, stalls the
// pipeline while outstanding, then reports load data or a fault for one cycle.
module mem_access_unit
   import rv_lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mem_mem_control,
   input  logic [ADDR_W-1:0] mem_result,
   input  logic [ADDR_W-1:0] mem_write_data,
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [ADDR_W-1:0] dbus_addr,
   output logic [ADDR_W-1:0] dbus_wdata,
   input  logic              dbus_ready,
   input  logic [ADDR_W-1:0] dbus_rdata,
   output logic              lsu_stall,
   output logic              lsu_load_valid,
   output logic [ADDR_W-1:0] lsu_load_data,
   output logic              lsu_fault,
   output logic [1:0]        lsu_fault_cause
);
   lsu_state_e        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] wdata_q, wdata_d;
   logic              load_valid_q, load_valid_d;
   logic [ADDR_W-1:0] load_data_q, load_data_d;
   logic              fault_q, fault_d;
   logic [1:0]        cause_q, cause_d;

   logic       access;
   logic [1:0] check_cause;
   logic       tmo_hit;
   logic       ctr_en;
   logic       ctr_clr;

   assign access      = (mem_mem_control != 2'b00);
   assign check_cause = legality_cause(mem_mem_control, mem_result[1:0]);
   assign ctr_en      = (state_q == WAIT);
   assign ctr_clr     = (state_q != WAIT) || dbus_ready || tmo_hit;

   lsu_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
      .clk   (clk),
      .reset (reset),
      .clr   (ctr_clr),
      .en    (ctr_en),
      .tc    (tmo_hit)
   );

   // Next-state and register-load decisions; everything holds by default.
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      load_valid_d = load_valid_q;
      load_data_d  = load_data_q;
      fault_d      = fault_q;
      cause_d      = cause_q;
      case (state_q)
         IDLE: begin
            if (!access) begin
               state_d = IDLE;
            end else if (check_cause != FAULT_NONE) begin
               state_d = DONE;
               fault_d = 1'b1;
               cause_d = check_cause;
            end else begin
               state_d = WAIT;
               req_d   = 1'b1;
               we_d    = mem_mem_control[CTRL_WRITE];
               addr_d  = {mem_result[ADDR_W-1:2], 2'b00};
               if (mem_mem_control[CTRL_WRITE]) begin
                  wdata_d = mem_write_data;
               end else begin
                  wdata_d = wdata_q;
               end
            end
         end
         WAIT: begin
            if (dbus_ready) begin
               state_d = DONE;
               req_d   = 1'b0;
               if (!we_q) begin
                  load_data_d  = dbus_rdata;
                  load_valid_d = 1'b1;
               end else begin
                  load_valid_d = 1'b0;
               end
            end else if (tmo_hit) begin
               state_d      = DONE;
               req_d        = 1'b0;
               fault_d      = 1'b1;
               cause_d      = FAULT_TIMEOUT;
               load_valid_d = 1'b0;
            end else begin
               state_d = WAIT;
            end
         end
         DONE: begin
            // Inputs still carry the finished access, so they are not looked at.
            state_d      = IDLE;
            load_valid_d = 1'b0;
            fault_d      = 1'b0;
         end
         default: begin
            state_d      = IDLE;
            req_d        = 1'b0;
            load_valid_d = 1'b0;
            fault_d      = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= {ADDR_W{1'b0}};
         wdata_q      <= {ADDR_W{1'b0}};
         load_valid_q <= 1'b0;
         load_data_q  <= {ADDR_W{1'b0}};
         fault_q      <= 1'b0;
         cause_q      <= FAULT_NONE;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         load_valid_q <= load_valid_d;
         load_data_q  <= load_data_d;
         fault_q      <= fault_d;
         cause_q      <= cause_d;
      end
   end

   // DONE drops the stall so EX/MEM advances exactly once per access.
   assign lsu_stall       = reset && (((state_q == IDLE) && access) || (state_q == WAIT));
   assign dbus_req        = req_q;
   assign dbus_we         = we_q;
   assign dbus_addr       = addr_q;
   assign dbus_wdata      = wdata_q;
   assign lsu_load_valid  = load_valid_q;
   assign lsu_load_data   = load_data_q;
   assign lsu_fault       = fault_q;
   assign lsu_fault_cause = cause_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of accesses with a bus
// responder and an expectation queue, plus reset corner-case sequences.
module tb_mem_access_unit;
   import rv_lsu_pkg::*;

   localparam int TMO = 8;
   localparam logic [7:0] NEVER = 8'hFF;

   typedef struct {
      logic [1:0]  ctrl;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  ready_at;   // req cycle index (0-based) carrying ready
      logic [31:0] rdata;
      int          exp_req;
      int          exp_stall;
      logic        exp_we;
      logic [31:0] exp_wdata;
      logic        exp_lv;
      logic [31:0] exp_ld;
      logic        exp_fault;
      logic [1:0]  exp_cause;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  mem_mem_control = 2'b00;
   logic [31:0] mem_result = 32'h0;
   logic [31:0] mem_write_data = 32'h0;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata;
   logic        dbus_ready = 1'b0;
   logic [31:0] dbus_rdata = 32'h0;
   logic        lsu_stall, lsu_load_valid, lsu_fault;
   logic [31:0] lsu_load_data;
   logic [1:0]  lsu_fault_cause;

   int n_vec = 0;
   int n_err = 0;
   vec_t sb_q[$];
   vec_t vecs[11];

   mem_access_unit #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_mem_control (mem_mem_control),
      .mem_result      (mem_result),
      .mem_write_data  (mem_write_data),
      .dbus_req        (dbus_req),
      .dbus_we         (dbus_we),
      .dbus_addr       (dbus_addr),
      .dbus_wdata      (dbus_wdata),
      .dbus_ready      (dbus_ready),
      .dbus_rdata      (dbus_rdata),
      .lsu_stall       (lsu_stall),
      .lsu_load_valid  (lsu_load_valid),
      .lsu_load_data   (lsu_load_data),
      .lsu_fault       (lsu_fault),
      .lsu_fault_cause (lsu_fault_cause)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
         n_err++;
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   req_cnt = 0;
      int   stall_cnt = 0;
      bit   done = 1'b0;
      vec_t e;
      sb_q.push_back(v);
      @(posedge clk); #1;
      mem_mem_control = v.ctrl;
      mem_result      = v.addr;
      mem_write_data  = v.wdata;
      dbus_ready      = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk($sformatf("v%0d lv_cleared", idx), {31'b0, lsu_load_valid}, 32'h0);
            chk($sformatf("v%0d fault_cleared", idx), {31'b0, lsu_fault}, 32'h0);
         end
         if (dbus_req) begin
            if (req_cnt == 0) begin
               chk($sformatf("v%0d we", idx), {31'b0, dbus_we}, {31'b0, v.exp_we});
               chk($sformatf("v%0d addr", idx), dbus_addr, {v.addr[31:2], 2'b00});
               chk($sformatf("v%0d wdata", idx), dbus_wdata, v.exp_wdata);
            end
            req_cnt++;
            if (v.ready_at != NEVER && req_cnt == int'(v.ready_at) + 1) begin
               dbus_ready = 1'b1;
               dbus_rdata = v.rdata;
            end else begin
               dbus_ready = 1'b0;
            end
         end else begin
            dbus_ready = 1'b0;
         end
         if (lsu_stall) begin
            stall_cnt++;
         end else begin
            done = 1'b1;
            e = sb_q.pop_front();
            chk($sformatf("v%0d load_valid", idx), {31'b0, lsu_load_valid}, {31'b0, e.exp_lv});
            chk($sformatf("v%0d load_data", idx), lsu_load_data, e.exp_ld);
            chk($sformatf("v%0d fault", idx), {31'b0, lsu_fault}, {31'b0, e.exp_fault});
            if (e.exp_fault) begin
               chk($sformatf("v%0d cause", idx), {30'b0, lsu_fault_cause}, {30'b0, e.exp_cause});
            end
            chk($sformatf("v%0d req_cycles", idx), req_cnt, e.exp_req);
            chk($sformatf("v%0d stall_cycles", idx), stall_cnt, e.exp_stall);
         end
      end
      if (!done) begin
         $display("FAIL v%0d completion: got no stall release expected release within 40 cycles", idx);
         n_err++;
         void'(sb_q.pop_front());
      end
      n_vec++;
   endtask

   initial begin
      //          ctrl   addr          wdata         rdy    rdata         req stl we    ewdata        lv    ld            flt   cause
      vecs[0]  = '{2'b10, 32'h0000_0100, 32'h0,        8'd2,  32'hDEADBEEF, 3, 4, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, FAULT_NONE};
      vecs[1]  = '{2'b01, 32'h0000_0204, 32'h12345678, 8'd0,  32'h0,        1, 2, 1'b1, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0, FAULT_NONE};
      vecs[2]  = '{2'b10, 32'h0000_0102, 32'h0,        NEVER, 32'h0,        0, 1, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, FAULT_MISALIGN};
      vecs[3]  = '{2'b11, 32'h0000_0200, 32'h0,        NEVER, 32'h0,        0, 1, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, FAULT_RW};
      vecs[4]  = '{2'b11, 32'h0000_0203, 32'h0,        NEVER, 32'h0,        0, 1, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, FAULT_RW};
      vecs[5]  = '{2'b10, 32'h0000_0300, 32'h0,        NEVER, 32'h0,        8, 9, 1'b0, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b1, FAULT_TIMEOUT};
      vecs[6]  = '{2'b10, 32'h0000_1004, 32'h0,        8'd0,  32'hCAFEF00D, 1, 2, 1'b0, 32'h12345678, 1'b1, 32'hCAFEF00D, 1'b0, FAULT_NONE};
      vecs[7]  = '{2'b01, 32'h0000_0008, 32'hA5A5A5A5, 8'd7,  32'h0,        8, 9, 1'b1, 32'hA5A5A5A5, 1'b0, 32'hCAFEF00D, 1'b0, FAULT_NONE};
      vecs[8]  = '{2'b01, 32'h0000_0001, 32'h5555AAAA, NEVER, 32'h0,        0, 1, 1'b1, 32'h0,        1'b0, 32'hCAFEF00D, 1'b1, FAULT_MISALIGN};
      vecs[9]  = '{2'b10, 32'hFFFF_FFFC, 32'h0,        8'd1,  32'h00000000, 2, 3, 1'b0, 32'hA5A5A5A5, 1'b1, 32'h00000000, 1'b0, FAULT_NONE};
      vecs[10] = '{2'b00, 32'h0000_0040, 32'h0,        NEVER, 32'h0,        0, 0, 1'b0, 32'h0,        1'b0, 32'h00000000, 1'b0, FAULT_NONE};

      // Reset held for 3 cycles with a pending read.
      reset = 1'b0;
      mem_mem_control = 2'b10;
      mem_result = 32'h0000_0040;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst req", {31'b0, dbus_req}, 32'h0);
         chk("rst we", {31'b0, dbus_we}, 32'h0);
         chk("rst addr", dbus_addr, 32'h0);
         chk("rst wdata", dbus_wdata, 32'h0);
         chk("rst lv", {31'b0, lsu_load_valid}, 32'h0);
         chk("rst ld", lsu_load_data, 32'h0);
         chk("rst fault", {31'b0, lsu_fault}, 32'h0);
         chk("rst cause", {30'b0, lsu_fault_cause}, 32'h0);
         chk("rst stall", {31'b0, lsu_stall}, 32'h0);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rel stall", {31'b0, lsu_stall}, 32'h1);
      chk("rel req_not_yet", {31'b0, dbus_req}, 32'h0);
      @(negedge clk);
      chk("rel req", {31'b0, dbus_req}, 32'h1);
      chk("rel addr", dbus_addr, 32'h0000_0040);
      dbus_ready = 1'b1;
      dbus_rdata = 32'h11112222;
      @(negedge clk);
      dbus_ready = 1'b0;
      chk("rel lv", {31'b0, lsu_load_valid}, 32'h1);
      chk("rel ld", lsu_load_data, 32'h11112222);
      chk("rel stall_done", {31'b0, lsu_stall}, 32'h0);
      n_vec++;

      for (int i = 0; i < 11; i++) begin
         run_vec(i, vecs[i]);
      end

      // Reset in the 2nd WAIT cycle, then a late ready.
      @(posedge clk); #1;
      mem_mem_control = 2'b10;
      mem_result = 32'h0000_0500;
      @(negedge clk);
      chk("mid stall_idle", {31'b0, lsu_stall}, 32'h1);
      @(negedge clk);
      chk("mid req_w1", {31'b0, dbus_req}, 32'h1);
      @(negedge clk);
      chk("mid req_w2", {31'b0, dbus_req}, 32'h1);
      reset = 1'b0;
      #1;
      chk("mid stall_in_reset", {31'b0, lsu_stall}, 32'h0);
      @(negedge clk);
      chk("mid req_after", {31'b0, dbus_req}, 32'h0);
      chk("mid stall_after", {31'b0, lsu_stall}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      mem_mem_control = 2'b00;
      dbus_ready = 1'b1;
      dbus_rdata = 32'h99999999;
      @(negedge clk);
      chk("late req", {31'b0, dbus_req}, 32'h0);
      chk("late stall", {31'b0, lsu_stall}, 32'h0);
      chk("late lv", {31'b0, lsu_load_valid}, 32'h0);
      @(negedge clk);
      chk("late lv2", {31'b0, lsu_load_valid}, 32'h0);
      chk("late ld", lsu_load_data, 32'h0);
      dbus_ready = 1'b0;
      n_vec++;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
